// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline: ALU op codes, the link register number and
// the multiplier FSM state type. The decode control unit uses the same package.
package pipe_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_MUL = 4'b1100;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mul_state_e;

endpackage

// File: rtl/pipeexe_if.sv
// Decode <-> execute bundle: decoded controls/operands in, EX results and the
// forwarding/stall feedback out.
interface pipeexe_if;

  logic        nostall;
  logic        dwreg;
  logic        dm2reg;
  logic        dwmem;
  logic [3:0]  daluc;
  logic        daluimm;
  logic        dshift;
  logic        djal;
  logic [31:0] da;
  logic [31:0] db;
  logic [31:0] dimm;
  logic [4:0]  drn;
  logic [31:0] dpc4;

  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [4:0]  ern;
  logic [31:0] ealu;
  logic [31:0] eb;
  logic        ebusy;

  modport master (
    output nostall, dwreg, dm2reg, dwmem, daluc, daluimm, dshift, djal,
    output da, db, dimm, drn, dpc4,
    input  ewreg, em2reg, ewmem, ern, ealu, eb, ebusy
  );

  modport slave (
    input  nostall, dwreg, dm2reg, dwmem, daluc, daluimm, dshift, djal,
    input  da, db, dimm, drn, dpc4,
    output ewreg, em2reg, ewmem, ern, ealu, eb, ebusy
  );

endinterface

// File: rtl/pipemul.sv
// Iterative shift-add multiplier: one partial product per cycle, low 32 bits kept.
// Operands must stay stable from the start edge until done.
module pipemul
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam logic [5:0] LastCnt = 6'(MUL_CYCLES - 1);

  mul_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [31:0] prod_q;
  logic [31:0] addend;

  // Step cnt adds a<<cnt when bit cnt of the multiplier is set.
  always_comb begin
    addend = '0;
    if (b[cnt_q[4:0]]) begin
      addend = a << cnt_q[4:0];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StBusy;
            cnt_q   <= '0;
            prod_q  <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          prod_q <= prod_q + addend;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q == StBusy);
  assign done    = (state_q == StDone);
  assign product = prod_q;

endmodule

// File: rtl/pipeexe.sv
// EX stage: ID/EX pipeline register, inline ALU, jal link path and the iterative
// multiplier whose busy flag freezes the front of the pipe.
module pipeexe
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       clrn,
  pipeexe_if.slave   bus
);

  logic        wreg_q, m2reg_q, wmem_q;
  logic [3:0]  aluc_q;
  logic        aluimm_q, shift_q, jal_q;
  logic [31:0] a_q, b_q, imm_q, pc4_q;
  logic [4:0]  rn_q;

  logic        mul_busy, mul_done, mul_start, load;
  logic [31:0] mul_product;
  logic [31:0] op_a, op_b, alu;

  assign load      = !mul_busy;
  assign mul_start = load && bus.nostall && bus.dwreg && (bus.daluc == ALU_MUL);

  // A stall from decode turns the entry into a bubble; data fields still load.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wreg_q   <= 1'b0;
      m2reg_q  <= 1'b0;
      wmem_q   <= 1'b0;
      aluc_q   <= '0;
      aluimm_q <= 1'b0;
      shift_q  <= 1'b0;
      jal_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      rn_q     <= '0;
      pc4_q    <= '0;
    end else if (load) begin
      wreg_q   <= bus.nostall & bus.dwreg;
      m2reg_q  <= bus.nostall & bus.dm2reg;
      wmem_q   <= bus.nostall & bus.dwmem;
      aluc_q   <= bus.nostall ? bus.daluc : ALU_ADD;
      aluimm_q <= bus.daluimm;
      shift_q  <= bus.dshift;
      jal_q    <= bus.djal;
      a_q      <= bus.da;
      b_q      <= bus.db;
      imm_q    <= bus.dimm;
      rn_q     <= bus.drn;
      pc4_q    <= bus.dpc4;
    end
  end

  assign op_a = shift_q ? {27'b0, imm_q[10:6]} : a_q;
  assign op_b = aluimm_q ? imm_q : b_q;

  always_comb begin
    alu = '0;
    case (aluc_q)
      ALU_ADD: alu = op_a + op_b;
      ALU_SUB: alu = op_a - op_b;
      ALU_AND: alu = op_a & op_b;
      ALU_OR:  alu = op_a | op_b;
      ALU_XOR: alu = op_a ^ op_b;
      ALU_LUI: alu = op_b << 16;
      ALU_SLL: alu = op_b << op_a[4:0];
      ALU_SRL: alu = op_b >> op_a[4:0];
      ALU_SRA: alu = 32'($signed(op_b) >>> op_a[4:0]);
      ALU_SLT: alu = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_MUL: alu = mul_done ? mul_product : '0;
      default: alu = '0;
    endcase
  end

  pipemul #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .clrn    (clrn),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // While the multiplier runs, MEM sees bubbles; ern stays live.
  assign bus.ewreg  = wreg_q & ~mul_busy;
  assign bus.em2reg = m2reg_q & ~mul_busy;
  assign bus.ewmem  = wmem_q & ~mul_busy;
  assign bus.ern    = jal_q ? REG_RA : rn_q;
  assign bus.ealu   = jal_q ? (pc4_q + 32'd4) : alu;
  assign bus.eb     = b_q;
  assign bus.ebusy  = mul_busy;

endmodule

// File: tb/tb_pipeexe.sv
// Directed bench for the EX stage: ALU ops, bubbles, jal, MUL timing and reset
// during a multiply, each against hand-computed values.
module tb_pipeexe;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_busy;
  int   n_wreg_hi;

  pipeexe_if bus ();

  pipeexe #(
    .MUL_CYCLES (32)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic nostall, input logic wreg, input logic m2reg,
                       input logic wmem, input logic [3:0] aluc, input logic aluimm,
                       input logic shift, input logic jal, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rn,
                       input logic [31:0] pc4);
    bus.nostall = nostall;
    bus.dwreg   = wreg;
    bus.dm2reg  = m2reg;
    bus.dwmem   = wmem;
    bus.daluc   = aluc;
    bus.daluimm = aluimm;
    bus.dshift  = shift;
    bus.djal    = jal;
    bus.da      = a;
    bus.db      = b;
    bus.dimm    = imm;
    bus.drn     = rn;
    bus.dpc4    = pc4;
  endtask

  initial begin
    drive(1, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_ewreg", 32'(bus.ewreg), 0);
    check("rst_em2reg", 32'(bus.em2reg), 0);
    check("rst_ewmem", 32'(bus.ewmem), 0);
    check("rst_ebusy", 32'(bus.ebusy), 0);
    check("rst_ern", 32'(bus.ern), 0);
    check("rst_eb", bus.eb, 0);
    check("rst_ealu", bus.ealu, 0);

    @(negedge clk);
    clrn = 1'b1;

    // ADD 5+7
    drive(1, 1, 0, 0, 4'b0001, 0, 0, 0, 5, 7, 0, 5'd3, 0);
    step();
    check("add_ealu", bus.ealu, 12);
    check("add_ewreg", 32'(bus.ewreg), 1);
    check("add_ern", 32'(bus.ern), 3);

    // Load-use bubble
    drive(0, 1, 1, 1, 4'b0001, 0, 0, 0, 1, 32'h1234, 0, 5'd4, 0);
    step();
    check("bub_ewreg", 32'(bus.ewreg), 0);
    check("bub_em2reg", 32'(bus.em2reg), 0);
    check("bub_ewmem", 32'(bus.ewmem), 0);
    check("bub_eb", bus.eb, 32'h1234);

    // SRA by shamt 4
    drive(1, 1, 0, 0, 4'b1001, 0, 1, 0, 0, 32'h8000_0000, 32'd4 << 6, 5'd5, 0);
    step();
    check("sra_ealu", bus.ealu, 32'hF800_0000);

    // jal
    drive(1, 1, 0, 0, 4'b0001, 0, 0, 1, 9, 9, 0, 5'd0, 32'h0040_0010);
    step();
    check("jal_ealu", bus.ealu, 32'h0040_0014);
    check("jal_ern", 32'(bus.ern), 31);
    check("jal_ewreg", 32'(bus.ewreg), 1);

    // SUB, SLT signed, LUI immediate, unlisted code
    drive(1, 1, 0, 0, 4'b0010, 0, 0, 0, 5, 7, 0, 5'd6, 0);
    step();
    check("sub_ealu", bus.ealu, 32'hFFFF_FFFE);
    drive(1, 1, 0, 0, 4'b1010, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 5'd6, 0);
    step();
    check("slt_ealu", bus.ealu, 1);
    drive(1, 1, 0, 0, 4'b0110, 1, 0, 0, 0, 0, 32'h1234, 5'd6, 0);
    step();
    check("lui_ealu", bus.ealu, 32'h1234_0000);
    drive(1, 1, 0, 0, 4'b1111, 0, 0, 0, 5, 7, 0, 5'd6, 0);
    step();
    check("bad_ealu", bus.ealu, 0);

    // MUL 3 x -1, then ADD 1+1 queued behind it
    drive(1, 1, 0, 0, 4'b1100, 0, 0, 0, 3, 32'hFFFF_FFFF, 0, 5'd7, 0);
    step();
    drive(1, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 1, 0, 5'd9, 0);
    n_busy = 0;
    n_wreg_hi = 0;
    while (bus.ebusy && n_busy < 40) begin
      if (bus.ewreg) n_wreg_hi++;
      n_busy++;
      step();
    end
    check("mul_busy_cycles", 32'(n_busy), 32);
    check("mul_ewreg_busy", 32'(n_wreg_hi), 0);
    check("mul_ealu", bus.ealu, 32'hFFFF_FFFD);
    check("mul_ewreg_done", 32'(bus.ewreg), 1);
    check("mul_ern", 32'(bus.ern), 7);
    step();
    check("post_mul_ealu", bus.ealu, 2);
    check("post_mul_ern", 32'(bus.ern), 9);
    check("post_mul_ebusy", 32'(bus.ebusy), 0);

    // Reset during a MUL
    drive(1, 1, 0, 0, 4'b1100, 0, 0, 0, 3, 5, 0, 5'd8, 0);
    step();
    drive(1, 1, 0, 0, 4'b0001, 0, 0, 0, 4, 5, 0, 5'd2, 0);
    for (int i = 0; i < 10; i++) step();
    check("mid_mul_ebusy", 32'(bus.ebusy), 1);
    clrn = 1'b0;
    #1;
    check("abort_ebusy", 32'(bus.ebusy), 0);
    check("abort_ewreg", 32'(bus.ewreg), 0);
    check("abort_ern", 32'(bus.ern), 0);
    check("abort_eb", bus.eb, 0);
    check("abort_ealu", bus.ealu, 0);
    @(negedge clk);
    clrn = 1'b1;
    step();
    check("after_rst_ealu", bus.ealu, 9);
    check("after_rst_ewreg", 32'(bus.ewreg), 1);
    check("after_rst_ern", 32'(bus.ern), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
